// File: rtl/serial_adder_seq_if.sv
`default_nettype none
// ============================================================================
// serial_adder_seq_if
// Operand/result bundle for the bit-serial adder/subtractor.
// Revision: 1.0
// ============================================================================
interface serial_adder_seq_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic             mode_sub;
  logic             serial_in_a;
  logic             serial_in_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             ovf_out;

  modport master (
    output start, mode_sub, serial_in_a, serial_in_b,
    input  busy, done, sum_out, carry_out, ovf_out
  );

  modport slave (
    input  start, mode_sub, serial_in_a, serial_in_b,
    output busy, done, sum_out, carry_out, ovf_out
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder_seq.sv
`default_nettype none
// ============================================================================
// serial_adder_seq
// LSB-first bit-serial adder/subtractor returning a parallel result with flags.
// Revision: 1.0
// ============================================================================
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  serial_adder_seq_if.slave bus
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             mode_q;
  logic             carry_q;
  logic [WIDTH-1:0] shreg_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             mode_eff;
  logic             cin;
  logic             b_eff;
  logic             s;
  logic             carry_d;
  logic [WIDTH-1:0] shreg_d;

  // In IDLE the start cycle carries bit 0, so mode and carry-in come straight
  // from the live mode_sub input rather than the latched copy.
  always_comb begin
    mode_eff = (state_q == IDLE) ? bus.mode_sub : mode_q;
    cin      = (state_q == IDLE) ? bus.mode_sub : carry_q;
    b_eff    = bus.serial_in_b ^ mode_eff;
    s        = bus.serial_in_a ^ b_eff ^ cin;
    carry_d  = (bus.serial_in_a & b_eff) | (bus.serial_in_a & cin) | (b_eff & cin);
    shreg_d  = {s, shreg_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_q  <= bus.mode_sub;
            carry_q <= carry_d;
            shreg_q <= shreg_d;
            cnt_q   <= CW'(1);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          carry_q <= carry_d;
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            // cin here is the carry into the MSB, carry_d the carry out of it.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            sum_q   <= shreg_d;
            cout_q  <= carry_d;
            ovf_q   <= cin ^ carry_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum_out   = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.ovf_out   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_seq.sv
`default_nettype none
// ============================================================================
// tb_serial_adder_seq
// Scoreboard bench for serial_adder_seq at WIDTH=8 and WIDTH=4.
// Revision: 1.0
// ============================================================================
module tb_serial_adder_seq;

  typedef struct {
    logic [7:0] sum;
    logic       c;
    logic       v;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t q8[$];
  exp_t q4[$];
  logic [9:0] last8 = '0;
  logic [9:0] last4 = '0;

  serial_adder_seq_if #(.WIDTH(8)) if8 ();
  serial_adder_seq_if #(.WIDTH(4)) if4 ();

  serial_adder_seq #(.WIDTH(8)) u_dut8 (.clk(clk), .reset(rst), .bus(if8));
  serial_adder_seq #(.WIDTH(4)) u_dut4 (.clk(clk), .reset(rst), .bus(if4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input bit sub);
    exp_t e;
    int lim  = 1 << w;
    int half = lim / 2;
    int ai   = int'(a);
    int bi   = int'(b);
    int full = sub ? ai - bi : ai + bi;
    int sa   = (ai >= half) ? ai - lim : ai;
    int sb   = (bi >= half) ? bi - lim : bi;
    int ss   = sub ? sa - sb : sa + sb;
    e.sum = 8'((full + lim) % lim);
    e.c   = sub ? (ai >= bi) : (full >= lim);
    e.v   = (ss >= half) || (ss < -half);
    e.cyc = 0;
    return e;
  endfunction

  task automatic drive(input bit sel, input logic st, input logic md, input logic a,
                       input logic b);
    if (sel) begin
      if4.start = st; if4.mode_sub = md; if4.serial_in_a = a; if4.serial_in_b = b;
    end else begin
      if8.start = st; if8.mode_sub = md; if8.serial_in_a = a; if8.serial_in_b = b;
    end
  endtask

  task automatic drive_idle(input bit sel);
    drive(sel, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Entered and left at posedge+1; leaves the DUT in its done cycle.
  task automatic op(input bit sel, input logic [7:0] a_in, input logic [7:0] b_in,
                    input bit sub, input bit inj);
    int         w = sel ? 4 : 8;
    logic [7:0] a = sel ? (a_in & 8'h0F) : a_in;
    logic [7:0] b = sel ? (b_in & 8'h0F) : b_in;
    exp_t       e;
    e     = model(w, a, b, sub);
    e.cyc = cyc + w;
    if (sel) q4.push_back(e); else q8.push_back(e);
    for (int i = 0; i < w; i++) begin
      if (i == 0)             drive(sel, 1'b1, sub, a[i], b[i]);
      else if (inj && i == 2) drive(sel, 1'b1, ~sub, a[i], b[i]);
      else                    drive(sel, 1'b0, 1'($urandom), a[i], b[i]);
      @(posedge clk); #1;
    end
    drive_idle(sel);
  endtask

  task automatic check(input bit sel, input logic done, input logic [7:0] sum,
                       input logic c, input logic v);
    exp_t e;
    logic [9:0] cur = {c, v, sum};
    if (done) begin
      if ((sel ? q4.size() : q8.size()) == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_done dut%0d: got done=1 required no pending op", sel ? 4 : 8);
      end else begin
        e = sel ? q4.pop_front() : q8.pop_front();
        compared++;
        if (cur !== {e.c, e.v, e.sum}) begin
          mismatched++;
          $display("FAIL result dut%0d: got sum=%h c=%b v=%b required sum=%h c=%b v=%b",
                   sel ? 4 : 8, sum, c, v, e.sum, e.c, e.v);
        end
        compared++;
        if (cyc != e.cyc) begin
          mismatched++;
          $display("FAIL latency dut%0d: got cycle %0d required cycle %0d",
                   sel ? 4 : 8, cyc, e.cyc);
        end
      end
      if (sel) last4 = cur; else last8 = cur;
    end else begin
      compared++;
      if (cur !== (sel ? last4 : last8)) begin
        mismatched++;
        $display("FAIL hold dut%0d: got %h required %h", sel ? 4 : 8, cur, sel ? last4 : last8);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last8 = '0;
      last4 = '0;
    end else begin
      check(1'b0, if8.done, if8.sum_out, if8.carry_out, if8.ovf_out);
      check(1'b1, if4.done, {4'h0, if4.sum_out}, if4.carry_out, if4.ovf_out);
    end
  end

  task automatic expect_zero(input string name, input logic [9:0] got);
    compared++;
    if (got !== 10'h000) begin
      mismatched++;
      $display("FAIL %s: got %h required 000", name, got);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    bit         done_wait;
    drive_idle(1'b0);
    drive_idle(1'b1);
    #1 rst = 1'b1;
    @(negedge clk);
    expect_zero("reset_state_dut8", {if8.busy, if8.done, if8.sum_out});
    expect_zero("reset_state_dut4", {if4.busy, if4.done, 4'h0, if4.sum_out});
    expect_zero("reset_flags", {6'h0, if8.carry_out, if8.ovf_out, if4.carry_out, if4.ovf_out});
    @(posedge clk); #1 rst = 1'b0;

    op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0);
    op(1'b0, 8'h10, 8'h20, 1'b1, 1'b0);
    op(1'b0, 8'h20, 8'h10, 1'b1, 1'b0);
    op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
    op(1'b0, 8'h01, 8'h01, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    op(1'b0, 8'h33, 8'h44, 1'b0, 1'b1);

    // Abort an operation after three bits with an asynchronous reset.
    ra = 8'hA5; rb = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, i == 0, 1'b0, ra[i], rb[i]);
      @(posedge clk); #1;
    end
    drive_idle(1'b0);
    #2 rst = 1'b1;
    #1;
    expect_zero("async_reset_dut8", {if8.busy, if8.done, if8.sum_out});
    expect_zero("async_reset_flags", {8'h0, if8.carry_out, if8.ovf_out});
    @(posedge clk); #1 rst = 1'b0;
    op(1'b0, 8'hC8, 8'h64, 1'b1, 1'b0);

    op(1'b1, 8'h07, 8'h01, 1'b0, 1'b0);
    op(1'b1, 8'h03, 8'h02, 1'b0, 1'b0);
    op(1'b1, 8'h02, 8'h05, 1'b1, 1'b1);

    for (int n = 0; n < 80; n++) begin
      op(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    done_wait = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      if (q8.size() == 0 && q4.size() == 0) begin
        done_wait = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    compared++;
    if (!done_wait || q8.size() != 0 || q4.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d/%0d pending required 0/0", q8.size(), q4.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
